// File: rtl/adc_frame_packer.sv
// adc_frame_packer: packs 8-bit ADC samples into framed byte packets
// (sync byte, sequence number, FRAME_LEN payload bytes, additive checksum)
// and writes them into the byte side of the downstream FIFO. A payload
// sample that meets a full FIFO aborts the frame and is counted as a drop.
module adc_frame_packer #(
  parameter int unsigned FRAME_LEN = 1024,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             wr_clk,
  input  logic             rst_n,
  input  logic [7:0]       adc_data,
  input  logic             adc_vld,
  input  logic             start,
  input  logic             cont,
  input  logic             clr_ovf,
  input  logic             fifo_full,
  output logic             fifo_wr_en,
  output logic [7:0]       fifo_wr_din,
  output logic             busy,
  output logic             frame_done,
  output logic [7:0]       frame_seq,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] drop_cnt
);

  // Index of the last payload byte; pay_cnt_r counts bytes already written.
  localparam logic [15:0]      LAST_IDX = 16'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR0    = 3'd1,
    ST_HDR1    = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CSUM    = 3'd4
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [7:0]       frame_seq_r;
  logic [15:0]      pay_cnt_r;
  logic [7:0]       csum_r;
  logic             ovf_sticky_r;
  logic [CNT_W-1:0] drop_cnt_r;

  logic             wr_en_s;
  logic [7:0]       wr_din_s;
  logic             done_s;
  logic             abort_s;
  logic             hdr1_wr_s;
  logic             pay_wr_s;

  // 8-bit modular checksum accumulation step.
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] data);
    csum_add = acc + data;
  endfunction

  // Next-state and FIFO write-side decode; write side is combinational so
  // payload bytes pass through with zero latency.
  always_comb begin
    state_nxt_s = state_r;
    wr_en_s     = 1'b0;
    wr_din_s    = 8'h00;
    done_s      = 1'b0;
    abort_s     = 1'b0;
    hdr1_wr_s   = 1'b0;
    pay_wr_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start || cont) begin
          state_nxt_s = ST_HDR0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_HDR0: begin
        wr_din_s = SYNC_BYTE;
        wr_en_s  = ~fifo_full;
        if (!fifo_full) begin
          state_nxt_s = ST_HDR1;
        end else begin
          state_nxt_s = ST_HDR0;
        end
      end
      ST_HDR1: begin
        wr_din_s = frame_seq_r;
        wr_en_s  = ~fifo_full;
        if (!fifo_full) begin
          hdr1_wr_s   = 1'b1;
          state_nxt_s = ST_PAYLOAD;
        end else begin
          state_nxt_s = ST_HDR1;
        end
      end
      ST_PAYLOAD: begin
        wr_din_s = adc_data;
        wr_en_s  = adc_vld & ~fifo_full;
        if (adc_vld && fifo_full) begin
          // The source cannot stall: losing a sample kills the frame.
          abort_s     = 1'b1;
          state_nxt_s = ST_IDLE;
        end else if (adc_vld) begin
          pay_wr_s = 1'b1;
          if (pay_cnt_r == LAST_IDX) begin
            state_nxt_s = ST_CSUM;
          end else begin
            state_nxt_s = ST_PAYLOAD;
          end
        end else begin
          state_nxt_s = ST_PAYLOAD;
        end
      end
      ST_CSUM: begin
        wr_din_s = csum_r;
        wr_en_s  = ~fifo_full;
        if (!fifo_full) begin
          done_s = 1'b1;
          if (cont) begin
            state_nxt_s = ST_HDR0;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_CSUM;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Payload byte counter and running checksum, restarted by the header write.
  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      pay_cnt_r <= 16'd0;
      csum_r    <= 8'h00;
    end else if (hdr1_wr_s) begin
      pay_cnt_r <= 16'd0;
      csum_r    <= 8'h00;
    end else if (pay_wr_s) begin
      pay_cnt_r <= pay_cnt_r + 16'd1;
      csum_r    <= csum_add(csum_r, adc_data);
    end else begin
      pay_cnt_r <= pay_cnt_r;
      csum_r    <= csum_r;
    end
  end

  // Sequence number advances on every completed or aborted frame so the
  // consumer sees a gap after a drop.
  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_seq_r <= 8'h00;
    end else if (done_s || abort_s) begin
      frame_seq_r <= frame_seq_r + 8'h01;
    end else begin
      frame_seq_r <= frame_seq_r;
    end
  end

  // Sticky overflow flag; a coincident abort beats the clear.
  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky_r <= 1'b0;
    end else if (abort_s) begin
      ovf_sticky_r <= 1'b1;
    end else if (clr_ovf) begin
      ovf_sticky_r <= 1'b0;
    end else begin
      ovf_sticky_r <= ovf_sticky_r;
    end
  end

  // Saturating count of aborted frames.
  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_r <= '0;
    end else if (abort_s && (drop_cnt_r != CNT_MAX)) begin
      drop_cnt_r <= drop_cnt_r + CNT_ONE;
    end else begin
      drop_cnt_r <= drop_cnt_r;
    end
  end

  assign fifo_wr_en  = wr_en_s;
  assign fifo_wr_din = wr_din_s;
  assign frame_done  = done_s;
  assign busy        = (state_r != ST_IDLE);
  assign frame_seq   = frame_seq_r;
  assign ovf_sticky  = ovf_sticky_r;
  assign drop_cnt    = drop_cnt_r;

endmodule

// File: doc/adc_frame_packer.md
Name: adc_frame_packer

Overview:
- Upstream stage of the byte-in/64-bit-out asynchronous FIFO; runs entirely in the wr_clk domain.
- Collects 8-bit ADC samples into framed byte packets: 2-byte header (sync byte, 8-bit sequence number), FRAME_LEN payload bytes, 1-byte checksum.
- Drives the FIFO write side (wr_din/wr_en) and honours its wr_full.
- Reports overflow drops so the consumer can resynchronise on the sync byte and detect sequence gaps.

Parameters:
- FRAME_LEN, 1024, payload bytes per frame; legal range 2..65535.
- SYNC_BYTE, 8'hA5, first header byte of every frame.
- CNT_W, 16, width of the saturating drop counter.

Ports:
- wr_clk  in  1  system/write clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- adc_data  in  8  ADC sample byte.
- adc_vld  in  1  adc_data valid this cycle; the source cannot stall.
- start  in  1  begin one frame; sampled in IDLE only.
- cont  in  1  continuous mode: restart frames back-to-back.
- clr_ovf  in  1  clear the ovf_sticky flag.
- fifo_full  in  1  FIFO wr_full.
- fifo_wr_en  out  1  FIFO write enable (combinational from state and inputs).
- fifo_wr_din  out  8  FIFO write data.
- busy  out  1  state != IDLE.
- frame_done  out  1  one-cycle pulse when the checksum byte is written.
- frame_seq  out  8  sequence number of the current or next frame.
- ovf_sticky  out  1  set on a payload overflow drop.
- drop_cnt  out  CNT_W  number of aborted frames; saturates at all-ones.

Behaviour:
- Reset values: state IDLE, frame_seq 0, pay_cnt 0, csum 0, ovf_sticky 0, drop_cnt 0, frame_done 0.
- Reset effect on outputs: fifo_wr_en is 0 while in IDLE; fifo_wr_din is 0 in IDLE.
- FSM states: IDLE, HDR0, HDR1, PAYLOAD, CSUM.
- IDLE -> HDR0 when start | cont.
- HDR0:
  - fifo_wr_din = SYNC_BYTE; fifo_wr_en = ~fifo_full.
  - Advance to HDR1 on a write; otherwise hold.
  - ADC samples arriving in HDR0/HDR1 are ignored and not counted as drops.
- HDR1:
  - fifo_wr_din = frame_seq; fifo_wr_en = ~fifo_full.
  - On write: advance to PAYLOAD; clear pay_cnt and csum.
- PAYLOAD:
  - fifo_wr_din = adc_data; fifo_wr_en = adc_vld & ~fifo_full.
  - Zero-latency pass-through.
  - On write: csum <= csum + adc_data (mod 256); pay_cnt++.
  - On the write where pay_cnt == FRAME_LEN-1: go to CSUM.
  - adc_vld=0: hold, no write.
- Overflow abort:
  - Condition: PAYLOAD & adc_vld & fifo_full.
  - Actions: no write; state -> IDLE; ovf_sticky <= 1; drop_cnt++ (saturating); frame_seq++.
  - No checksum is emitted. The partial frame stays in the FIFO, and the consumer discards it via the sync/sequence check.
- CSUM:
  - fifo_wr_din = csum; fifo_wr_en = ~fifo_full; stall allowed.
  - On write: frame_done = 1 for that cycle (combinational with the write); frame_seq++ (wraps 255 -> 0).
  - Next state: HDR0 if cont, else IDLE.
- start while busy is ignored; cont deasserted mid-frame finishes the current frame.
- clr_ovf & abort in the same cycle: set wins.
- Throughput: at most one FIFO write per cycle; the header and trailer cost 3 cycles minimum per frame.
- Asynchronous reset mid-frame: immediately IDLE with all counters cleared; the partial frame remains in the FIFO.

Test Plan (FRAME_LEN=4 unless noted):
- Single frame:
  - Stimulus: reset, start pulse, fifo_full=0, adc_vld=1 with data 01,02,03,04.
  - Expected: writes A5,00,01,02,03,04,0A on 7 consecutive cycles; frame_done on the 0A cycle; frame_seq -> 1; busy low afterwards.
- Stall on header:
  - Stimulus: fifo_full=1 for 3 cycles during HDR0, then 0.
  - Expected: no write while full; A5 written on the first non-full cycle; no drop counted.
- Overflow abort:
  - Stimulus: fifo_full rises with adc_vld=1 on the 3rd payload byte.
  - Expected: fifo_wr_en=0 that cycle; ovf_sticky=1; drop_cnt=1; frame_seq=1; state IDLE; next frame header byte is 01.
- Continuous mode:
  - Stimulus: cont=1 for 3 frames of constant data FF.
  - Expected: checksum FC each frame; sequence 00,01,02; HDR0 directly follows the CSUM write; frame_done pulses 3 times.
- Clear and saturation:
  - Stimulus: CNT_W=2, force 4 aborts.
  - Expected: drop_cnt stays at 3.
  - Stimulus: clr_ovf coincident with an abort.
  - Expected: ovf_sticky remains 1.
- Reset mid-payload:
  - Stimulus: assert rst_n low during PAYLOAD.
  - Expected: fifo_wr_en=0 immediately; frame_seq=0; restart emits A5,00.
